// File: rtl/gysc_sample_fifo.sv
// Three-axis sample FIFO with decimation, watermark and fifo/stream/bypass overrun handling.
// Latency: a write strobe or pop at cycle N is visible on level/outputs at N+1.
// Backpressure: none upstream; when full, fifo mode discards new samples and stream mode drops the oldest.
//
// Ports:
//   clk, rst                           clock, synchronous active-high reset
//   sample_valid, x/y/z_filter_data    one-cycle sample pulse with per-axis data
//   fifo_write_ctrl[3:0]               decimation divider (store one of every DIV+1 samples)
//   fifo_mode_ctrl[1:0], [7:4]         mode (00/11 bypass, 01 fifo, 10 stream), watermark
//   rd_req                             one-cycle pop request
//   ovr_clr                            clears the sticky overrun flag
//   x/y/z_fifo_out, rd_valid           last popped entry and its one-cycle update pulse
//   fifo_level/empty/full/wtm/ovr      status
module gysc_sample_fifo #(
   parameter int DEPTH = 16,
   parameter int DW    = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     sample_valid,
   input  logic [DW-1:0]            x_filter_data,
   input  logic [DW-1:0]            y_filter_data,
   input  logic [DW-1:0]            z_filter_data,
   input  logic [7:0]               fifo_write_ctrl,
   input  logic [7:0]               fifo_mode_ctrl,
   input  logic                     rd_req,
   input  logic                     ovr_clr,
   output logic [DW-1:0]            x_fifo_out,
   output logic [DW-1:0]            y_fifo_out,
   output logic [DW-1:0]            z_fifo_out,
   output logic                     rd_valid,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     fifo_empty,
   output logic                     fifo_full,
   output logic                     fifo_wtm,
   output logic                     fifo_ovr
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   localparam logic [1:0]    MODE_FIFO   = 2'b01;
   localparam logic [1:0]    MODE_STREAM = 2'b10;
   localparam logic [DW-1:0] OUT_NAN     = DW'(32'h7FC0_0000);

   logic [3*DW-1:0] r_mem [DEPTH];
   logic [AW-1:0]   r_wp;
   logic [AW-1:0]   r_rp;
   logic [LW-1:0]   r_level;
   logic [3:0]      r_dec_cnt;
   logic [3:0]      r_div_prev;
   logic [1:0]      r_mode_prev;
   logic            r_ovr;
   logic            r_rd_valid;
   logic [DW-1:0]   r_x_out;
   logic [DW-1:0]   r_y_out;
   logic [DW-1:0]   r_z_out;

   logic [1:0] w_mode;
   logic [3:0] w_div;
   logic [3:0] w_wtm;
   logic       w_mode_chg;
   logic       w_div_chg;
   logic       w_active;
   logic       w_strobe;
   logic       w_full;
   logic       w_empty;
   logic       w_wr;
   logic       w_pop;
   logic       w_store;
   logic       w_drop;
   logic       w_ovr_set;
   logic       w_lvl_inc;
   logic       w_lvl_dec;

   assign w_mode     = fifo_mode_ctrl[1:0];
   assign w_div      = fifo_write_ctrl[3:0];
   assign w_wtm      = fifo_mode_ctrl[7:4];
   assign w_mode_chg = (w_mode != r_mode_prev);
   assign w_div_chg  = (w_div != r_div_prev);

   // Storage only operates in fifo/stream mode and not in the cycle the mode changes;
   // otherwise the queue is flushed.
   assign w_active   = ((w_mode == MODE_FIFO) || (w_mode == MODE_STREAM)) && !w_mode_chg;

   // A divider change restarts decimation and suppresses the strobe in that cycle.
   assign w_strobe   = sample_valid && !w_div_chg && (r_dec_cnt == w_div);

   assign w_full     = (r_level == LW'(DEPTH));
   assign w_empty    = (r_level == '0);
   assign w_wr       = w_active && w_strobe;
   // Pop qualifies on stored level only: a same-cycle write into an empty queue never falls through.
   assign w_pop      = w_active && rd_req && !w_empty;
   // A concurrent pop frees a slot, so a full queue accepts the write without overrun.
   assign w_store    = w_wr && (!w_full || w_pop || (w_mode == MODE_STREAM));
   assign w_drop     = w_wr && w_full && !w_pop && (w_mode == MODE_STREAM);
   assign w_ovr_set  = w_wr && w_full && !w_pop;
   assign w_lvl_inc  = w_store && !w_pop && !w_drop;
   assign w_lvl_dec  = w_pop && !w_store;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_dec_cnt <= '0;
      end else if (w_div_chg) begin
         r_dec_cnt <= '0;
      end else if (sample_valid) begin
         if (r_dec_cnt == w_div) r_dec_cnt <= '0;
         else                    r_dec_cnt <= r_dec_cnt + 4'd1;
      end
   end

   // Storage array has no reset; pointers and level define what is valid.
   always_ff @(posedge clk) begin
      if (!rst && w_store) begin
         r_mem[r_wp] <= {x_filter_data, y_filter_data, z_filter_data};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wp        <= '0;
         r_rp        <= '0;
         r_level     <= '0;
         r_ovr       <= 1'b0;
         r_rd_valid  <= 1'b0;
         r_x_out     <= OUT_NAN;
         r_y_out     <= OUT_NAN;
         r_z_out     <= OUT_NAN;
         // Capture current controls so leaving reset is not seen as a change.
         r_div_prev  <= w_div;
         r_mode_prev <= w_mode;
      end else begin
         r_div_prev  <= w_div;
         r_mode_prev <= w_mode;
         if (!w_active) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_level    <= '0;
            r_rd_valid <= 1'b0;
            if (w_mode_chg)   r_ovr <= 1'b0;
            else if (ovr_clr) r_ovr <= 1'b0;
         end else begin
            r_rd_valid <= w_pop;
            if (w_pop) begin
               {r_x_out, r_y_out, r_z_out} <= r_mem[r_rp];
            end
            if (w_store)          r_wp <= r_wp + AW'(1);
            if (w_pop || w_drop)  r_rp <= r_rp + AW'(1);
            if (w_lvl_inc)        r_level <= r_level + LW'(1);
            else if (w_lvl_dec)   r_level <= r_level - LW'(1);
            // A new overrun in the same cycle as a clear leaves the flag set.
            if (w_ovr_set)        r_ovr <= 1'b1;
            else if (ovr_clr)     r_ovr <= 1'b0;
         end
      end
   end

   assign x_fifo_out = r_x_out;
   assign y_fifo_out = r_y_out;
   assign z_fifo_out = r_z_out;
   assign rd_valid   = r_rd_valid;
   assign fifo_level = r_level;
   assign fifo_ovr   = r_ovr;
   assign fifo_empty = w_empty;
   assign fifo_full  = w_full;
   assign fifo_wtm   = (w_wtm != 4'd0) && (r_level >= LW'(w_wtm));

endmodule

// File: tb/tb_gysc_sample_fifo.sv
// Directed bench for gysc_sample_fifo: reset state, decimation, fifo/stream overrun,
// simultaneous push/pop when full or empty, watermark, mode-change flush and bypass.
module tb_gysc_sample_fifo;

   localparam int DW = 32;

   logic          clk;
   logic          rst;
   logic          sample_valid;
   logic [DW-1:0] x_filter_data;
   logic [DW-1:0] y_filter_data;
   logic [DW-1:0] z_filter_data;
   logic [7:0]    fifo_write_ctrl;
   logic [7:0]    fifo_mode_ctrl;
   logic          rd_req;
   logic          ovr_clr;
   logic [DW-1:0] x_fifo_out;
   logic [DW-1:0] y_fifo_out;
   logic [DW-1:0] z_fifo_out;
   logic          rd_valid;
   logic [4:0]    fifo_level;
   logic          fifo_empty;
   logic          fifo_full;
   logic          fifo_wtm;
   logic          fifo_ovr;

   int n_checks = 0;
   int n_errors = 0;

   gysc_sample_fifo #(.DEPTH(16), .DW(DW)) dut (
      .clk             (clk),
      .rst             (rst),
      .sample_valid    (sample_valid),
      .x_filter_data   (x_filter_data),
      .y_filter_data   (y_filter_data),
      .z_filter_data   (z_filter_data),
      .fifo_write_ctrl (fifo_write_ctrl),
      .fifo_mode_ctrl  (fifo_mode_ctrl),
      .rd_req          (rd_req),
      .ovr_clr         (ovr_clr),
      .x_fifo_out      (x_fifo_out),
      .y_fifo_out      (y_fifo_out),
      .z_fifo_out      (z_fifo_out),
      .rd_valid        (rd_valid),
      .fifo_level      (fifo_level),
      .fifo_empty      (fifo_empty),
      .fifo_full       (fifo_full),
      .fifo_wtm        (fifo_wtm),
      .fifo_ovr        (fifo_ovr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] x);
      sample_valid  = 1'b1;
      x_filter_data = x;
      y_filter_data = x + 32'd100;
      z_filter_data = x + 32'd200;
      tick();
      sample_valid  = 1'b0;
   endtask

   task automatic pop();
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
   endtask

   task automatic set_ctrl(input logic [7:0] mode_ctrl, input logic [7:0] wr_ctrl);
      fifo_mode_ctrl  = mode_ctrl;
      fifo_write_ctrl = wr_ctrl;
      tick();
   endtask

   initial begin
      rst             = 1'b1;
      sample_valid    = 1'b0;
      x_filter_data   = '0;
      y_filter_data   = '0;
      z_filter_data   = '0;
      fifo_write_ctrl = 8'h00;
      fifo_mode_ctrl  = 8'h00;
      rd_req          = 1'b0;
      ovr_clr         = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      chk("rst_x",     x_fifo_out, 32'h7fc00000);
      chk("rst_y",     y_fifo_out, 32'h7fc00000);
      chk("rst_z",     z_fifo_out, 32'h7fc00000);
      chk("rst_empty", 32'(fifo_empty), 32'd1);
      chk("rst_full",  32'(fifo_full),  32'd0);
      chk("rst_level", 32'(fifo_level), 32'd0);
      chk("rst_ovr",   32'(fifo_ovr),   32'd0);
      chk("rst_rdv",   32'(rd_valid),   32'd0);

      // Decimation DIV=2: samples 3, 6, 9 are kept
      set_ctrl(8'h01, 8'h02);
      for (int i = 1; i <= 9; i++) begin
         push(32'(i));
         tick();
      end
      chk("dec_level", 32'(fifo_level), 32'd3);
      for (int i = 1; i <= 3; i++) begin
         pop();
         chk("dec_rdv", 32'(rd_valid), 32'd1);
         chk("dec_x", x_fifo_out, 32'(3 * i));
         chk("dec_z", z_fifo_out, 32'(3 * i + 200));
         tick();
         chk("dec_rdv_pulse", 32'(rd_valid), 32'd0);
      end
      chk("dec_empty", 32'(fifo_empty), 32'd1);

      // FIFO mode overrun: 17th sample discarded
      set_ctrl(8'h01, 8'h00);
      for (int i = 1; i <= 17; i++) push(32'(i));
      chk("ovf_full",  32'(fifo_full),  32'd1);
      chk("ovf_ovr",   32'(fifo_ovr),   32'd1);
      chk("ovf_level", 32'(fifo_level), 32'd16);
      chk("ovf_wtm0",  32'(fifo_wtm),   32'd0);
      for (int i = 1; i <= 16; i++) begin
         pop();
         chk("ovf_x", x_fifo_out, 32'(i));
      end
      chk("ovf_empty", 32'(fifo_empty), 32'd1);
      pop();
      chk("ovf_extra_rdv", 32'(rd_valid), 32'd0);
      chk("ovf_extra_x",   x_fifo_out,    32'd16);

      // Stream mode: oldest dropped, mode change clears ovr
      set_ctrl(8'h02, 8'h00);
      chk("strm_chg_ovr",   32'(fifo_ovr),   32'd0);
      chk("strm_chg_level", 32'(fifo_level), 32'd0);
      for (int i = 1; i <= 20; i++) push(32'(i));
      chk("strm_level", 32'(fifo_level), 32'd16);
      chk("strm_ovr",   32'(fifo_ovr),   32'd1);
      pop();
      chk("strm_x",      x_fifo_out,       32'd5);
      chk("strm_level2", 32'(fifo_level),  32'd15);
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      chk("strm_ovr_clr", 32'(fifo_ovr), 32'd0);

      // Full FIFO, simultaneous write and pop
      set_ctrl(8'h01, 8'h00);
      chk("sim_flush", 32'(fifo_level), 32'd0);
      for (int i = 1; i <= 16; i++) push(32'(i));
      chk("sim_full", 32'(fifo_full), 32'd1);
      sample_valid  = 1'b1;
      x_filter_data = 32'd99;
      y_filter_data = 32'd199;
      z_filter_data = 32'd299;
      rd_req        = 1'b1;
      tick();
      sample_valid  = 1'b0;
      rd_req        = 1'b0;
      chk("sim_rdv",   32'(rd_valid),   32'd1);
      chk("sim_x",     x_fifo_out,      32'd1);
      chk("sim_level", 32'(fifo_level), 32'd16);
      chk("sim_ovr",   32'(fifo_ovr),   32'd0);
      for (int i = 2; i <= 16; i++) begin
         pop();
         chk("sim_drain_x", x_fifo_out, 32'(i));
      end
      pop();
      chk("sim_last_x", x_fifo_out, 32'd99);
      chk("sim_last_y", y_fifo_out, 32'd199);
      chk("sim_empty",  32'(fifo_empty), 32'd1);

      // Watermark 4 in fifo mode (mode bits unchanged, no flush)
      set_ctrl(8'h41, 8'h00);
      for (int i = 1; i <= 3; i++) push(32'(i));
      chk("wtm_3", 32'(fifo_wtm), 32'd0);
      push(32'd4);
      chk("wtm_4", 32'(fifo_wtm), 32'd1);
      for (int i = 5; i <= 17; i++) push(32'(i));
      chk("wtm_ovr", 32'(fifo_ovr), 32'd1);
      set_ctrl(8'h42, 8'h00);
      chk("chg_level", 32'(fifo_level), 32'd0);
      chk("chg_wtm",   32'(fifo_wtm),   32'd0);
      chk("chg_ovr",   32'(fifo_ovr),   32'd0);

      // Empty queue, same-cycle write and pop: write stored, no fall-through
      sample_valid  = 1'b1;
      x_filter_data = 32'd55;
      rd_req        = 1'b1;
      tick();
      sample_valid  = 1'b0;
      rd_req        = 1'b0;
      chk("nft_rdv",   32'(rd_valid),   32'd0);
      chk("nft_level", 32'(fifo_level), 32'd1);
      chk("nft_x_hold", x_fifo_out,     32'd99);
      pop();
      chk("nft_pop_x", x_fifo_out, 32'd55);

      // Bypass mode ignores writes and pops
      set_ctrl(8'h00, 8'h00);
      push(32'd77);
      chk("byp_level", 32'(fifo_level), 32'd0);
      pop();
      chk("byp_rdv", 32'(rd_valid), 32'd0);
      chk("byp_x",   x_fifo_out,    32'd55);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/gysc_sample_fifo.md
GYSC_SAMPLE_FIFO -- requirements
Module: gysc_sample_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entry count (power of 2).
REQ-002 SHALL have parameter DW, default 32, per-axis sample width (IEEE-754 single).
REQ-003 SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 sample_valid  input  1  one-cycle pulse; x/y/z_filter_data valid.
REQ-007 x_filter_data, y_filter_data, z_filter_data  input  DW each  filtered axis samples.
REQ-008 fifo_write_ctrl  input  8  [3:0] decimation divider DIV; [7:4] unused.
REQ-009 fifo_mode_ctrl  input  8  [1:0] MODE (00 bypass, 01 fifo, 10 stream, 11 = bypass); [7:4] watermark WTM; [3:2] unused.
REQ-010 rd_req  input  1  one-cycle pop request.
REQ-011 ovr_clr  input  1  clears overrun flag.
REQ-012 x_fifo_out, y_fifo_out, z_fifo_out  output  DW each  last popped entry, registered.
REQ-013 rd_valid  output  1  pulses one cycle when outputs updated by a pop.
REQ-014 fifo_level  output  5  stored entry count, 0..16.
REQ-015 fifo_empty, fifo_full  output  1 each  level==0 / level==DEPTH.
REQ-016 fifo_wtm  output  1  WTM!=0 and level>=WTM.
REQ-017 fifo_ovr  output  1  sticky overrun flag.

Function
REQ-018 Entry SHALL be {x,y,z} (3*DW bits), stored in order; read returns oldest entry first.
REQ-019 Decimation SHALL count sample_valid pulses with dec_cnt (4 bit); write strobe when dec_cnt==DIV, then dec_cnt<=0; else dec_cnt+1. DIV=0 writes every sample.
REQ-020 Any change of fifo_write_ctrl[3:0] from its previous-cycle value SHALL zero dec_cnt that cycle; no write strobe that cycle.
REQ-021 Write strobe at cycle N SHALL make entry stored and fifo_level updated at N+1.
REQ-022 rd_req at cycle N with level>0 SHALL load oldest entry into x/y/z_fifo_out and assert rd_valid at N+1; level decrements.
REQ-023 rd_req with level==0 (and no same-cycle write) SHALL be ignored: outputs hold, rd_valid=0.
REQ-024 Simultaneous write strobe and valid pop SHALL both complete; level unchanged; full FIFO does not overrun in this case in either mode.
REQ-025 Simultaneous write and rd_req when empty SHALL store the write only; no rd_valid (no fall-through).
REQ-026 MODE fifo, full, write without pop: sample SHALL be discarded, fifo_ovr<=1.
REQ-027 MODE stream, full, write without pop: oldest entry SHALL be dropped (read pointer +1), new entry stored, level stays 16, fifo_ovr<=1.
REQ-028 MODE bypass: SHALL flush (pointers and level to 0) every cycle, ignore writes and rd_req, rd_valid=0; outputs hold.
REQ-029 Any change of MODE SHALL flush pointers/level and clear fifo_ovr that cycle; writes that cycle discarded.
REQ-030 ovr_clr SHALL clear fifo_ovr; simultaneous new overrun wins (flag stays 1).
REQ-031 Pointers SHALL be log2(DEPTH) bits, wrap modulo DEPTH; level tracked separately (DEPTH+1 values).
REQ-032 fifo_empty, fifo_full, fifo_wtm SHALL be combinational from registered level/WTM.

Reset
REQ-033 rst SHALL set pointers, level, dec_cnt to 0, fifo_ovr=0, rd_valid=0.
REQ-034 rst SHALL set x/y/z_fifo_out to 32'h7fc00000 (invalid NaN).
REQ-035 rst asserted mid-operation SHALL override all same-cycle writes/pops; storage contents need not clear.

Verification
REQ-036 Reset, read outputs -> all three outs 0x7fc00000, empty=1, level=0, ovr=0.
REQ-037 MODE=01, DIV=2, 9 sample_valid pulses with x=1..9 -> level=3; three pops give x=3,6,9 each with rd_valid one cycle after rd_req.
REQ-038 MODE=01, DIV=0, 17 writes x=1..17 -> full=1, ovr=1, level=16; 16 pops return x=1..16 then empty=1; extra pop -> rd_valid=0.
REQ-039 MODE=10, DIV=0, 20 writes x=1..20 -> level=16, ovr=1; first pop returns x=5; ovr_clr -> ovr=0.
REQ-040 Full FIFO (MODE=01), same-cycle write x=99 and rd_req -> pop returns x=1, level stays 16, ovr stays 0; x=99 read last.
REQ-041 WTM=4, 4 writes -> fifo_wtm=1 at 4th level update; change MODE 01->10 -> level=0, wtm=0, ovr=0 next cycle.
